// File: rtl/mux_scan_ctrl_if.sv
// Bus bundle between mux_scan_ctrl, the 16:1 mux it steers and the
// downstream consumer of the sampled channel data.
interface mux_scan_ctrl_if #(
    parameter int DW = 8
);
    logic [3:0]    a;
    logic          en;
    logic [DW-1:0] d;
    logic [DW-1:0] dout;
    logic [3:0]    ch_out;
    logic          out_valid;
    logic          out_ready;

    // The scan controller drives the mux select and the sample stream.
    modport master (
        output a, en, dout, ch_out, out_valid,
        input  d, out_ready
    );

    // The mux/consumer side returns mux data and the ready handshake.
    modport slave (
        input  a, en, dout, ch_out, out_valid,
        output d, out_ready
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 16:1 analog/digital mux through its channels,
// waits DWELL settle cycles on each one, samples the mux output and hands
// it downstream with a valid/ready handshake.
// Optional feature: define MUX_SCAN_MASK_EN to add a ch_mask input that
// skips channels whose mask bit is 0. Without it, all 16 channels are
// scanned in order 0..15.
module mux_scan_ctrl #(
    parameter int DW    = 8,
    parameter int DWELL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
`ifdef MUX_SCAN_MASK_EN
    input  logic [15:0] ch_mask,
`endif
    output logic        busy,
    output logic        done,
    mux_scan_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        OUT,
        DONE
    } state_t;

    localparam logic [3:0] DWELL_CNT = 4'(DWELL);

    state_t        state_q, state_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [3:0]    ch_q, ch_d;

    // Channel set used for the current scan and the one offered at start.
    logic [15:0]   scan_mask;
    logic [15:0]   start_mask;
    logic [4:0]    first_hit;
    logic [4:0]    next_hit;

`ifdef MUX_SCAN_MASK_EN
    logic [15:0]   mask_q, mask_d;
    assign scan_mask  = mask_q;
    assign start_mask = ch_mask;
`else
    assign scan_mask  = 16'hFFFF;
    assign start_mask = 16'hFFFF;
`endif

    // Returns {found, index} of the lowest set mask bit at or above 'from';
    // a 5-bit 'from' lets 16 mean "nothing left above channel 15".
    function automatic logic [4:0] lowest_from(input logic [15:0] m,
                                               input logic [4:0]  from);
        logic [4:0] r;
        r = 5'b0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i] && (5'(i) >= from)) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

    // Next-state, datapath updates and output decode for the scan FSM.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ch_d    = ch_q;
`ifdef MUX_SCAN_MASK_EN
        mask_d  = mask_q;
`endif

        first_hit = lowest_from(start_mask, 5'd0);
        next_hit  = lowest_from(scan_mask, {1'b0, a_q} + 5'd1);

        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef MUX_SCAN_MASK_EN
                    mask_d = start_mask;
`endif
                    if (first_hit[4]) begin
                        a_d     = first_hit[3:0];
                        cnt_d   = DWELL_CNT;
                        state_d = SEL;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SEL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    dout_d  = bus.d;
                    ch_d    = a_q;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            OUT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    if (next_hit[4]) begin
                        a_d     = next_hit[3:0];
                        cnt_d   = DWELL_CNT;
                        state_d = SEL;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bus.a         = a_q;
        bus.en        = (state_q == SEL);
        bus.dout      = dout_q;
        bus.ch_out    = ch_q;
        bus.out_valid = (state_q == OUT);
        busy          = (state_q == SEL) || (state_q == OUT);
        done          = (state_q == DONE);
    end

    // State and datapath registers; rst returns everything to a clean IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            ch_q    <= '0;
`ifdef MUX_SCAN_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ch_q    <= ch_d;
`ifdef MUX_SCAN_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed and randomized scans of mux_scan_ctrl against
// a timestamp-based reference model of the expected channel sequence.
module tb_mux_scan_ctrl;

    localparam int DW    = 8;
    localparam int DWELL = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [DW-1:0] dxor;
`ifdef MUX_SCAN_MASK_EN
    logic [15:0]   ch_mask;
`endif

    int checks = 0;
    int errors = 0;

    mux_scan_ctrl_if #(.DW(DW)) bus ();

    // The mux model: each channel returns its own index scrambled by dxor.
    assign bus.d = DW'(bus.a) ^ dxor;

    // Free-running clock.
    always #5 clk = ~clk;

    mux_scan_ctrl #(.DW(DW), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask (ch_mask),
`endif
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    // One comparison with failure accounting.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives the control inputs for the cycle that follows this negedge.
    task automatic applyStimulus(input logic st, input logic ab, input logic rdy);
        start         = st;
        abort         = ab;
        bus.out_ready = rdy;
    endtask

    // Everything quiet, as after reset, abort or a finished scan.
    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_en"}, 32'(bus.en), 0);
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
    endtask

    // One scan: the expected channels are the enabled mask bits in order.
    // Every output appears DWELL+2 cycles after its trigger (start or the
    // previous transfer); done follows the last transfer by one cycle.
    task automatic runScan(input logic [15:0] mask, input int ready_pct,
                           input int hold_idx, input int abort_idx,
                           input bit noise, input logic [DW-1:0] xv);
        int          exp_ch[$];
        int          trig;
        int          idx;
        int          holds;
        int          elapsed;
        bit          fin;
        bit          valid_e;
        logic        rdy;
        logic        ab;
        logic        st;
        logic [15:0] m;
`ifdef MUX_SCAN_MASK_EN
        m = mask;
`else
        m = 16'hFFFF;
`endif
        for (int c = 0; c < 16; c++) begin
            if (m[c]) exp_ch.push_back(c);
        end
        dxor = xv;
        @(negedge clk);
        checkQuiet("pre_start");
`ifdef MUX_SCAN_MASK_EN
        ch_mask = mask;
`endif
        applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)));
        trig  = 0;
        idx   = 0;
        holds = 0;
        fin   = 1'b0;
        for (int k = 1; k < 2000 && !fin; k++) begin
            @(negedge clk);
            elapsed = k - trig;
            if (idx < exp_ch.size()) begin
                valid_e = (elapsed >= DWELL + 2);
                checkOutput("scan_en", 32'(bus.en), 32'(elapsed <= DWELL + 1));
                checkOutput("scan_busy", 32'(busy), 1);
                checkOutput("scan_done", 32'(done), 0);
                checkOutput("scan_valid", 32'(bus.out_valid), 32'(valid_e));
                checkOutput("scan_a", 32'(bus.a), 32'(exp_ch[idx]));
                if (valid_e) begin
                    checkOutput("scan_ch_out", 32'(bus.ch_out), 32'(exp_ch[idx]));
                    checkOutput("scan_dout", 32'(bus.dout), 32'(DW'(exp_ch[idx]) ^ dxor));
                end
                rdy = ($urandom_range(99) < ready_pct);
                if (valid_e && idx == hold_idx && holds < 5) begin
                    rdy = 1'b0;
                    holds++;
                end
                ab = valid_e && (idx == abort_idx);
                st = noise ? 1'($urandom_range(1)) : 1'b0;
                applyStimulus(st, ab, rdy);
                if (ab) begin
                    @(negedge clk);
                    checkQuiet("after_abort");
                    applyStimulus(1'b0, 1'b0, 1'b0);
                    fin = 1'b1;
                end else if (valid_e && rdy) begin
                    idx++;
                    trig = k;
                end
            end else begin
                checkOutput("done_pulse", 32'(done), 1);
                checkOutput("done_busy", 32'(busy), 0);
                checkOutput("done_valid", 32'(bus.out_valid), 0);
                checkOutput("done_en", 32'(bus.en), 0);
                applyStimulus(noise ? 1'($urandom_range(1)) : 1'b0, 1'b0,
                              1'($urandom_range(1)));
                @(negedge clk);
                checkQuiet("after_done");
                applyStimulus(1'b0, 1'b0, 1'b0);
                fin = 1'b1;
            end
        end
        if (!fin) checkOutput("scan_timeout", 1, 0);
    endtask

    // Directed scenarios first, then randomized scans.
    initial begin
        bit found;
        rst  = 1'b1;
        dxor = '0;
`ifdef MUX_SCAN_MASK_EN
        ch_mask = 16'hFFFF;
`endif
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_a", 32'(bus.a), 0);
        checkOutput("rst_dout", 32'(bus.dout), 0);
        checkOutput("rst_ch_out", 32'(bus.ch_out), 0);
        checkQuiet("rst");
        rst = 1'b0;

        $display("[TB] full scan");
        runScan(16'hFFFF, 100, -1, -1, 1'b0, '0);

        $display("[TB] backpressure at channel 3");
        runScan(16'hFFFF, 100, 3, -1, 1'b1, DW'($urandom));

        $display("[TB] abort at channel 7, then rescan");
        runScan(16'hFFFF, 100, -1, 7, 1'b1, DW'($urandom));
        runScan(16'hFFFF, 100, -1, -1, 1'b0, DW'($urandom));

        $display("[TB] reset during SEL of channel 5");
        dxor = '0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (bus.a == 4'd5 && bus.en) begin
                found = 1'b1;
            end else begin
                applyStimulus(1'b1, 1'b0, 1'b1);
            end
        end
        checkOutput("reach_ch5", 32'(found), 1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("midrst_a", 32'(bus.a), 0);
        checkOutput("midrst_dout", 32'(bus.dout), 0);
        checkOutput("midrst_ch_out", 32'(bus.ch_out), 0);
        checkQuiet("midrst");
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkQuiet("post_rst");
        end

`ifdef MUX_SCAN_MASK_EN
        $display("[TB] masked scan 8005");
        runScan(16'h8005, 100, -1, -1, 1'b1, DW'($urandom));
        $display("[TB] empty mask");
        runScan(16'h0000, 100, -1, -1, 1'b1, DW'($urandom));
`endif

        $display("[TB] randomized scans");
        for (int r = 0; r < 8; r++) begin
            logic [15:0] rm;
            rm = 16'($urandom);
            if (r == 3) rm = 16'h0000;
            runScan(rm, $urandom_range(30, 100), $urandom_range(15),
                    (r % 2 == 1) ? int'($urandom_range(15)) : -1,
                    1'b1, DW'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
